// File: rtl/decoder_proj_pkg.sv
// Shared defaults and FSM state type for the decoder input conditioner.
package decoder_proj_pkg;

  localparam int WIDTH_DEF         = 7;
  localparam int STABLE_CYCLES_DEF = 4;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } cond_state_t;

endpackage

// File: rtl/decoder_in_sync2.sv
// Two-flop synchronizer, one independent flop pair per pad bit.
module decoder_in_sync2
  import decoder_proj_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_q;
      logic sync_q;

      // Metastability-settling flop followed by the stable output flop.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
        end else begin
          meta_q <= async_i[gi];
          sync_q <= meta_q;
        end
      end

      assign sync_o[gi] = sync_q;
    end
  endgenerate

endmodule

// File: rtl/decoder_in_conditioner.sv
// Pad-code conditioner: synchronizes io_in, qualifies a new code once it has
// been seen STABLE_CYCLES consecutive samples, and presents it with a
// valid/ready handshake. Optional sticky overrun flag enabled by the macro
// DECODER_IN_OVERRUN_EN.
module decoder_in_conditioner
  import decoder_proj_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] io_in,
  output logic [WIDTH-1:0] out_code,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DECODER_IN_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  // Counter only ever needs to reach STABLE_CYCLES-1.
  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync2;
  cond_state_t      state_q;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_code_q;
  logic             out_valid_q;
  logic             commit;

  decoder_in_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .async_i (io_in),
    .sync_o  (sync2)
  );

  // Candidate has been held long enough on this sample: accept it now.
  assign commit = (state_q == SETTLE) && (sync2 == cand_q) && (cnt_q == CNT_LAST);

  // Qualification FSM plus the registered handshake outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= STABLE;
      cand_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_code_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        STABLE: begin
          if (sync2 != acc_q) begin
            cand_q  <= sync2;
            cnt_q   <= CNT_ONE;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != cand_q) begin
            // Glitch: back to idle if the old code reappeared, else restart.
            if (sync2 == acc_q) begin
              state_q <= STABLE;
            end else begin
              cand_q <= sync2;
              cnt_q  <= CNT_ONE;
            end
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_ONE;
          end else begin
            // Commit overrides a same-edge handshake clear.
            acc_q       <= cand_q;
            out_code_q  <= cand_q;
            out_valid_q <= 1'b1;
            state_q     <= STABLE;
          end
        end
        default: state_q <= STABLE;
      endcase
    end
  end

  assign out_code  = out_code_q;
  assign out_valid = out_valid_q;

`ifdef DECODER_IN_OVERRUN_EN
  logic overrun_q;

  // Sticky: a pending code was replaced before the decoder took it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overrun_q <= 1'b0;
    end else if (commit && out_valid_q && !out_ready) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

endmodule

// File: doc/decoder_in_conditioner.md
DECODER_IN_CONDITIONER -- requirements
Module: decoder_in_conditioner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, meaning the width of the pad code fed to the decoder.
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples needed to accept a code; legal range 2..255.
REQ-003 Port clock  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-004 Port reset_n  input  1  is the reset, synchronous and active-low.
REQ-005 Port io_in  input  WIDTH  carries the raw asynchronous pad inputs.
REQ-006 Port out_code  output  WIDTH  carries the accepted code presented to the decoder.
REQ-007 Port out_valid  output  1  means out_code holds an unconsumed accepted code.
REQ-008 Port out_ready  input  1  means the downstream decoder accepts out_code this cycle.
REQ-009 Port overrun  output  1  is a sticky flag: an unconsumed code was overwritten (present only per REQ-024).

Function
REQ-010 io_in SHALL pass through a 2-flop synchronizer; sync2 denotes the second flop output.
REQ-011 The FSM SHALL have two states:
- STABLE: sync2 equals the last accepted code (acc).
- SETTLE: a candidate code (cand) is being qualified.
REQ-012 In STABLE, when sync2 != acc, the FSM SHALL load cand<=sync2 and cnt<=1, then enter SETTLE.
REQ-013 In SETTLE with sync2 == cand and cnt < STABLE_CYCLES-1, the FSM SHALL increment cnt.
REQ-014 In SETTLE with sync2 != cand (glitch), the FSM SHALL reload cand<=sync2 and cnt<=1, then stay in SETTLE; if sync2 == acc it SHALL instead return to STABLE with no event.
REQ-015 Commit: in SETTLE with sync2 == cand and cnt == STABLE_CYCLES-1, the block SHALL set acc<=cand, out_code<=cand and out_valid<=1, then enter STABLE.
REQ-016 Latency: with io_in changed before edge k and held, out_valid SHALL be high after edge k+STABLE_CYCLES+1 (k+5 at the default).
REQ-017 Handshake: out_valid SHALL stay high and out_code SHALL stay constant until an edge where out_valid && out_ready; that edge SHALL clear out_valid unless a commit occurs on the same edge.
REQ-018 Commit while out_valid && !out_ready: out_code SHALL be overwritten with the new code, out_valid SHALL stay 1, and overrun SHALL be set.
REQ-019 Commit on the same edge as a completed handshake: the new code SHALL load, out_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-020 cnt SHALL be a minimal-width unsigned counter that saturates at STABLE_CYCLES-1 and never wraps.

Reset
REQ-021 With reset_n low at an edge, the sync flops, cand, acc, out_code, cnt and overrun SHALL all clear to 0, out_valid SHALL clear to 0, and the state SHALL become STABLE.
REQ-022 After reset, an all-zero io_in SHALL produce no event; the first stable non-zero code SHALL produce one.
REQ-023 Reset asserted mid-SETTLE or with out_valid pending SHALL discard the candidate and the pending code, and SHALL NOT raise overrun.

Configuration
REQ-024 Macro DECODER_IN_OVERRUN_EN:
- Defined: the overrun port and its sticky register SHALL exist per REQ-018.
- Undefined: the port and register SHALL be absent; the overwrite behaviour of REQ-018 SHALL remain unchanged.

Structure
REQ-025 Package decoder_proj_pkg SHALL hold the WIDTH default, the STABLE_CYCLES default and the FSM state enum (STABLE, SETTLE).
REQ-026 The synchronizer SHALL be a sub-module named decoder_in_sync2, WIDTH-parameterized, two flops per bit, synchronous active-low reset.

Verification
REQ-027 Basic accept: reset, then io_in=7'b1101100 held, out_ready=0 -> out_valid rises after edge k+5, out_code=7'h6C, overrun=0.
REQ-028 Glitch reject: io_in=7'h6C for 2 cycles, then 7'h00 -> no out_valid ever, and the FSM returns to STABLE.
REQ-029 Glitch restart: 7'h6C for 2 cycles, 7'h13 for 1 cycle, then 7'h6C held -> a single commit of 7'h6C, timed from the last change.
REQ-030 Overrun: accept 7'h6C with out_ready=0, then 7'h01 stable -> out_code=7'h01, out_valid=1, overrun=1 (sticky through a later handshake).
REQ-031 Simultaneous: out_ready=1 on the exact edge a commit of 7'h2A occurs -> out_valid stays 1, out_code=7'h2A, overrun=0.
REQ-032 Reset mid-operation: reset_n=0 for 1 cycle during SETTLE with out_valid pending -> all outputs 0 next cycle; 7'h00 held -> no event.
